// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout unit (50/20/10/5 sen) with a per-tube
// coin inventory that is reloaded in maintenance mode.
// Optional feature macro: CHANGE_DISPENSER_AUDIT_EN adds the saturating
// total_paid accumulator and its output port.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        refund,
    input  logic [9:0]  change,
    input  logic        maintenance,
    input  logic        load,
    input  logic [1:0]  load_sel,
    input  logic [7:0]  load_count,
    output logic [3:0]  coin_eject,
    output logic        busy,
    output logic        done,
    output logic        short,
    output logic [9:0]  remaining,
    output logic [3:0]  empty,
    output logic [2:0]  state
`ifdef CHANGE_DISPENSER_AUDIT_EN
    ,
    output logic [15:0] total_paid
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_amount;
    logic [1:0]  r_coin_sel;
    logic [15:0] r_tick;
    logic [7:0]  r_count [4];
    logic [7:0]  w_count_next [4];
    logic [3:0]  w_empty_next;

    logic        w_accept;
    logic        w_load_en;
    logic        w_pulse_last;
    logic        w_gap_last;
    logic        w_coin_out;
    logic        w_found;
    logic [1:0]  w_pick;
    logic [1:0]  w_eject_sel;
    logic [3:0]  w_eject_next;
    logic        w_busy_next;
    logic        w_done_next;

    // Tube index to coin value in sen (bit order matches load_sel)
    function automatic logic [9:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd3:    return 10'd50;
            2'd2:    return 10'd20;
            2'd1:    return 10'd10;
            default: return 10'd5;
        endcase
    endfunction

    assign w_accept     = (r_state == S_IDLE) && refund && !maintenance;
    assign w_load_en    = (r_state == S_IDLE) && maintenance && load;
    assign w_pulse_last = (r_tick == 16'(PULSE_CYCLES - 1));
    assign w_gap_last   = (r_tick == 16'(GAP_CYCLES - 1));
    // Last cycle of an eject pulse: the coin is counted as paid here
    assign w_coin_out   = (r_state == S_EJECT) && w_pulse_last;

    // Largest affordable denomination that still has coins; later (larger) tubes win
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_count[i] != 8'd0 && coin_value(2'(i)) <= r_amount) begin
                w_found = 1'b1;
                w_pick  = 2'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_SELECT;
            S_SELECT: w_state_next = (r_amount == 10'd0 || !w_found) ? S_DONE : S_EJECT;
            S_EJECT:  if (w_pulse_last) w_state_next = S_GAP;
            S_GAP:    if (w_gap_last) w_state_next = S_SELECT;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        w_eject_sel  = (r_state == S_SELECT) ? w_pick : r_coin_sel;
        w_eject_next = (w_state_next == S_EJECT) ? (4'b0001 << w_eject_sel) : 4'b0000;
        w_busy_next  = (w_state_next != S_IDLE);
        w_done_next  = (w_state_next == S_DONE);
    end

    // Registered outputs; remaining/short are captured on entry to DONE and held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coin_eject <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
            remaining  <= 10'd0;
        end else begin
            coin_eject <= w_eject_next;
            busy       <= w_busy_next;
            done       <= w_done_next;
            if (w_done_next) begin
                remaining <= r_amount;
                short     <= (r_amount != 10'd0);
            end
        end
    end

    // Cycle counter for eject pulse and inter-coin gap; restarts on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                               r_tick <= 16'd0;
        else if (w_state_next != r_state)                       r_tick <= 16'd0;
        else if (r_state == S_EJECT || r_state == S_GAP)        r_tick <= r_tick + 16'd1;
    end

    // Amount register and latched coin selection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_amount   <= 10'd0;
            r_coin_sel <= 2'd0;
        end else begin
            if (w_accept)        r_amount <= change;
            else if (w_coin_out) r_amount <= r_amount - coin_value(r_coin_sel);
            if (r_state == S_SELECT) r_coin_sel <= w_pick;
        end
    end

    // Per-tube next count (load in maintenance, decrement on paid coin) and empty flag
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tube
            assign w_count_next[gi] =
                (w_load_en && load_sel == 2'(gi))       ? load_count :
                (w_coin_out && r_coin_sel == 2'(gi))    ? r_count[gi] - 8'd1 :
                                                          r_count[gi];
            assign w_empty_next[gi] = (r_count[gi] == 8'd0);
        end
    endgenerate

    // Inventory counters and registered empty flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) r_count[i] <= 8'd0;
            empty <= 4'b1111;
        end else begin
            for (int i = 0; i < 4; i++) r_count[i] <= w_count_next[i];
            empty <= w_empty_next;
        end
    end

    assign state = r_state;

`ifdef CHANGE_DISPENSER_AUDIT_EN
    logic [15:0] r_total_paid;
    logic [16:0] w_total_sum;

    assign w_total_sum = {1'b0, r_total_paid} + {7'd0, coin_value(r_coin_sel)};

    // Saturating audit total; cleared by loading tube 0 with zero in maintenance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_total_paid <= 16'd0;
        else if (w_load_en && load_sel == 2'd0 && load_count == 8'd0)
            r_total_paid <= 16'd0;
        else if (w_coin_out)
            r_total_paid <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
    end

    assign total_paid = r_total_paid;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized
// payouts compared against a greedy-payout reference model with its own inventory.
module tb_change_dispenser;

    localparam int P = 4;
    localparam int G = 2;
    localparam int S = 1 + P + G;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       refund = 1'b0;
    logic [9:0] change = 10'd0;
    logic       maintenance = 1'b0;
    logic       load = 1'b0;
    logic [1:0] load_sel = 2'd0;
    logic [7:0] load_count = 8'd0;
    logic [3:0] coin_eject;
    logic       busy;
    logic       done;
    logic       short;
    logic [9:0] remaining;
    logic [3:0] empty;
    logic [2:0] state;
`ifdef CHANGE_DISPENSER_AUDIT_EN
    logic [15:0] total_paid;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int inv[4];
    int den[4] = '{5, 10, 20, 50};
    int paid_model = 0;

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .refund     (refund),
        .change     (change),
        .maintenance(maintenance),
        .load       (load),
        .load_sel   (load_sel),
        .load_count (load_count),
        .coin_eject (coin_eject),
        .busy       (busy),
        .done       (done),
        .short      (short),
        .remaining  (remaining),
        .empty      (empty),
        .state      (state)
`ifdef CHANGE_DISPENSER_AUDIT_EN
        ,
        .total_paid (total_paid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_empty();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = (inv[i] == 0);
        return e;
    endfunction

    task automatic load_tube(input int sel, input int cnt);
        maintenance = 1'b1;
        load        = 1'b1;
        load_sel    = 2'(sel);
        load_count  = 8'(cnt);
        tick();
        load        = 1'b0;
        maintenance = 1'b0;
        inv[sel]    = cnt;
        if (sel == 0 && cnt == 0) paid_model = 0;
        tick();
        $display("[TB] load tube=%0d count=%0d", sel, cnt);
    endtask

    // Start a payout, follow it cycle by cycle against the model's expected trace
    task automatic do_payout(input int amt, input bit extra_refund, input bit mid_maint);
        int coins[$];
        int rem;
        int pick;
        int k;
        int done_off;
        int mis_eject;
        int mis_busy;
        int mis_done;
        int j;
        int off;
        logic [3:0] exp_ej;

        mis_eject = 0;
        mis_busy  = 0;
        mis_done  = 0;
        rem = amt;
        while (1) begin
            pick = -1;
            for (int i = 3; i >= 0; i--) begin
                if (den[i] <= rem && inv[i] > 0) begin
                    pick = i;
                    break;
                end
            end
            if (pick < 0) break;
            coins.push_back(pick);
            rem -= den[pick];
            inv[pick]--;
            paid_model = (paid_model + den[pick] > 65535) ? 65535 : paid_model + den[pick];
        end
        k        = coins.size();
        done_off = 2 + k * S;

        refund = 1'b1;
        change = 10'(amt);
        tick();
        refund = 1'b0;
        for (int t = 1; t <= done_off; t++) begin
            exp_ej = 4'b0000;
            if (t >= 2) begin
                j   = (t - 2) / S;
                off = (t - 2) % S;
                if (j < k && off < P) exp_ej = 4'b0001 << coins[j];
            end
            if (coin_eject !== exp_ej) mis_eject++;
            if (busy !== 1'b1) mis_busy++;
            if (done !== (t == done_off)) mis_done++;
            if (t == done_off) begin
                check("remaining", remaining, rem);
                check("short", short, (rem != 0) ? 1 : 0);
            end
            refund = (extra_refund && t == 3);
            if (t == 3) change = 10'd30;
            maintenance = mid_maint && (t >= 2) && (t < done_off);
            if (t < done_off) tick();
        end
        refund      = 1'b0;
        maintenance = 1'b0;
        tick();
        check("eject_trace", mis_eject, 0);
        check("busy_trace", mis_busy, 0);
        check("done_timing", mis_done, 0);
        check("done_after", done, 0);
        check("busy_after", busy, 0);
        check("state_after", state, 0);
        tick();
        check("empty", empty, exp_empty());
`ifdef CHANGE_DISPENSER_AUDIT_EN
        check("total_paid", total_paid, paid_model);
`endif
        $display("[TB] payout amt=%0d coins=%0d remaining=%0d cycles=%0d", amt, k, rem, done_off);
    endtask

    initial begin
        int dones;
        int amt;

        for (int i = 0; i < 4; i++) inv[i] = 0;

        // Reset state
        #23;
        check("rst_state", state, 0);
        check("rst_eject", coin_eject, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_short", short, 0);
        check("rst_remaining", remaining, 0);
        check("rst_empty", empty, 15);
        rst = 1'b1;
        tick();

        // Full tubes, 85 sen -> 50, 20, 10, 5
        for (int i = 0; i < 4; i++) load_tube(i, 10);
        check("empty_loaded", empty, 0);
        do_payout(85, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check("count_after_85", inv[i], 9);

        // 50 tube empty, 20 tube 10 -> five 20s
        load_tube(3, 0);
        load_tube(2, 10);
        check("empty50", empty[3], 1);
        do_payout(100, 1'b0, 1'b0);
        check("count20", inv[2], 5);

        // Non-multiple of 5 leaves a remainder
        for (int i = 0; i < 4; i++) load_tube(i, 10);
        do_payout(7, 1'b0, 1'b0);

        // Zero amount: done two cycles after the strobe, no ejects
        do_payout(0, 1'b0, 1'b0);

        // Second refund while busy is ignored; maintenance mid-payout does not abort
        do_payout(60, 1'b1, 1'b1);

        // Maintenance blocks payout, then load tube 2 with 3 coins
        maintenance = 1'b1;
        refund      = 1'b1;
        change      = 10'd55;
        tick();
        refund = 1'b0;
        check("maint_state", state, 0);
        check("maint_busy", busy, 0);
        tick();
        check("maint_state2", state, 0);
        maintenance = 1'b0;
        load_tube(2, 0);
        load_tube(2, 3);
        check("empty20_loaded", empty[2], 0);
        do_payout(40, 1'b0, 1'b0);

        // Randomized reloads and payouts
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 1) == 1) load_tube(i, int'($urandom_range(0, 4)));
            amt = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 300));
            do_payout(amt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset during the second coin pulse of a 60-sen payout
        for (int i = 0; i < 4; i++) load_tube(i, 10);
        refund = 1'b1;
        change = 10'd60;
        tick();
        refund = 1'b0;
        tick();
        check("rp_first_coin", coin_eject, 4'b1000);
        refund = 1'b1;
        change = 10'd30;
        tick();
        refund = 1'b0;
        for (int t = 3; t < 9; t++) tick();
        check("rp_second_coin", coin_eject, 4'b0010);
        tick();
        rst = 1'b0;
        #1;
        check("rp_eject", coin_eject, 0);
        check("rp_state", state, 0);
        check("rp_empty", empty, 15);
        check("rp_busy", busy, 0);
        check("rp_done", done, 0);
        for (int i = 0; i < 4; i++) inv[i] = 0;
        paid_model = 0;
        #1;
        rst = 1'b1;
        dones = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("rp_no_done", dones, 0);
        check("rp_empty_after", empty, 15);
        $display("[TB] reset mid-payout sequence complete");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
